ff256_ct_seq_byte_sequencer: RTL and testbench

- Controller that accepts a 64-bit word, holds it, and steps an 8:1 byte selector to emit the word as 8 bytes over 8 output beats.
- Sits between the sequential cosine-transform word datapath and the byte-wide output stream.
- Generates the 3-bit selector for the 64->8 byte mux and exposes the selected byte.
- Provides valid/ready handshakes on both sides, with zero-bubble back-to-back words.

---
 rtl/ff256_ct_seq_byte_sequencer.sv | 75 +++++++
 tb/tb_ff256_ct_seq_byte_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ff256_ct_seq_byte_sequencer.sv
// Word-to-byte sequencer: holds a 64-bit word and steps an 8:1 byte mux over 8 output beats.
// Define FF256_CT_SEQ_BYTE_MSB_FIRST_EN to emit the most-significant byte first.
module ff256_ct_seq_byte_sequencer #(
  parameter int NUM_BYTES = 8,
  parameter int CNT_W     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] x_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             x_out,
  output logic [CNT_W-1:0]       selector,
  output logic                   out_last,
  output logic                   busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BYTES - 1);

`ifdef FF256_CT_SEQ_BYTE_MSB_FIRST_EN
  localparam logic [CNT_W-1:0] SEL_FIRST = CNT_LAST;
`else
  localparam logic [CNT_W-1:0] SEL_FIRST = '0;
`endif

  logic [0:0]                 state;
  logic [CNT_W-1:0]           cnt;
  logic [CNT_W-1:0]           sel;
  logic [NUM_BYTES-1:0][7:0]  hold;
  logic                       accept;
  logic                       xfer;

  assign out_valid = (state == SEND);
  assign busy      = out_valid;
  assign out_last  = (state == SEND) && (cnt == CNT_LAST);
  assign in_ready  = (state == IDLE) || (out_last && out_ready);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign selector  = sel;
  // sel is always a legal index into hold, so x_out is never X
  assign x_out     = hold[sel];

  // Selector is its own register so it reads 0 in IDLE even in the MSB-first build.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sel   <= '0;
      hold  <= '0;
    end else if (accept) begin
      hold  <= x_in;
      cnt   <= '0;
      sel   <= SEL_FIRST;
      state <= SEND;
    end else if (xfer) begin
      if (out_last) begin
        state <= IDLE;
        cnt   <= '0;
        sel   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
`ifdef FF256_CT_SEQ_BYTE_MSB_FIRST_EN
        sel <= sel - CNT_W'(1);
`else
        sel <= sel + CNT_W'(1);
`endif
      end
    end
  end

endmodule

// File: tb/tb_ff256_ct_seq_byte_sequencer.sv
// Directed table-driven bench for ff256_ct_seq_byte_sequencer, plus a hand-written stalled-stream sequence.
// Honors FF256_CT_SEQ_BYTE_MSB_FIRST_EN when the bench is built with the same define as the RTL.
module tb_ff256_ct_seq_byte_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] x_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  x_out;
  logic [2:0]  selector;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ff256_ct_seq_byte_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out), .selector(selector),
    .out_last(out_last), .busy(busy)
  );

`ifdef FF256_CT_SEQ_BYTE_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  // One cycle: inputs driven, expected outputs before the next rising edge.
  typedef struct {
    bit          chk;
    bit          rst;
    bit          iv;
    logic [63:0] xin;
    bit          ordy;
    bit          e_ir;
    bit          e_ov;
    int          e_beat;  // beat index 0..7 when e_ov
    logic [63:0] e_word;  // word in the hold register
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit chk, input bit r, input bit iv, input logic [63:0] xin,
                     input bit ordy, input bit e_ir, input bit e_ov, input int e_beat,
                     input logic [63:0] e_word);
    vec_t v;
    v.chk = chk; v.rst = r; v.iv = iv; v.xin = xin; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_beat = e_beat; v.e_word = e_word;
    tbl.push_back(v);
  endtask

  function automatic logic [2:0] sel_of(input int beat);
    return MSB ? 3'(7 - beat) : 3'(beat);
  endfunction

  localparam logic [63:0] W1 = 64'h8877665544332211;
  localparam logic [63:0] WA = 64'h0706050403020100;
  localparam logic [63:0] WB = 64'h0F0E0D0C0B0A0908;
  localparam logic [63:0] W3 = 64'hFFEEDDCCBBAA9988;
  localparam logic [63:0] W4 = 64'h0123456789ABCDEF;
  localparam logic [63:0] W5 = 64'h1;

  initial begin
    logic [14:0] act, exp;
    logic [2:0]  esel;
    logic [7:0]  got[$];
    logic [63:0] w;
    bit          done;

    // reset, then single word
    add(0, 1, 0, 0, 1, 1, 0, 0, 0);
    add(1, 1, 0, 0, 1, 1, 0, 0, 0);
    add(1, 0, 1, W1, 1, 1, 0, 0, 0);
    for (int k = 0; k < 8; k++) add(1, 0, 0, 0, 1, k == 7, 1, k, W1);
    add(1, 0, 0, 0, 1, 1, 0, 0, W1);
    // back-to-back words, no gap
    add(1, 0, 1, WA, 1, 1, 0, 0, W1);
    for (int k = 0; k < 8; k++) add(1, 0, 1, WB, 1, k == 7, 1, k, WA);
    for (int k = 0; k < 8; k++) add(1, 0, 0, 0, 1, k == 7, 1, k, WB);
    add(1, 0, 0, 0, 1, 1, 0, 0, WB);
    // backpressure at beat 3
    add(1, 0, 1, W3, 1, 1, 0, 0, WB);
    for (int k = 0; k < 3; k++) add(1, 0, 0, 0, 1, 0, 1, k, W3);
    for (int s = 0; s < 3; s++) add(1, 0, 0, 0, 0, 0, 1, 3, W3);
    for (int k = 3; k < 8; k++) add(1, 0, 0, 0, 1, k == 7, 1, k, W3);
    add(1, 0, 0, 0, 1, 1, 0, 0, W3);
    // input held off while busy, accepted on the last-beat transfer
    add(1, 0, 1, W4, 1, 1, 0, 0, W3);
    for (int k = 0; k < 8; k++) add(1, 0, 1, W5, 1, k == 7, 1, k, W4);
    for (int k = 0; k < 8; k++) add(1, 0, 0, 0, 1, k == 7, 1, k, W5);
    add(1, 0, 0, 0, 1, 1, 0, 0, W5);
    // reset mid-word at beat 4
    add(1, 0, 1, W3, 1, 1, 0, 0, W5);
    for (int k = 0; k < 4; k++) add(1, 0, 0, 0, 1, 0, 1, k, W3);
    add(1, 1, 0, 0, 1, 0, 1, 4, W3);
    add(1, 0, 0, 0, 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1, 0, 0, 0);

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      rst = tbl[i].rst; in_valid = tbl[i].iv; x_in = tbl[i].xin; out_ready = tbl[i].ordy;
      @(negedge clk);
      if (tbl[i].chk) begin
        esel = tbl[i].e_ov ? sel_of(tbl[i].e_beat) : 3'd0;
        exp  = {tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_ov, tbl[i].e_ov && tbl[i].e_beat == 7,
                esel, tbl[i].e_word[8*esel +: 8]};
        act  = {in_ready, out_valid, busy, out_last, selector, x_out};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL vec%0d {ir,ov,busy,last,sel,x_out} got %b_%b_%b_%b_%0d_%h want %b_%b_%b_%b_%0d_%h",
                   i, act[14], act[13], act[12], act[11], act[10:8], act[7:0],
                   exp[14], exp[13], exp[12], exp[11], exp[10:8], exp[7:0]);
        end
      end
    end

    // stream with out_ready toggling every cycle; collect bytes until the last transfer
    w = 64'hDEADBEEFCAFEF00D;
    @(posedge clk); #1;
    rst = 0; in_valid = 1; x_in = w; out_ready = 0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL toggle_accept in_ready got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 0; x_in = '0;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      out_ready = c[0];
      @(negedge clk);
      if (out_valid && out_ready) begin
        got.push_back(x_out);
        if (out_last) done = 1;
      end
      @(posedge clk); #1;
    end
    out_ready = 0;
    checks++;
    if (!done || got.size() != 8) begin
      errors++;
      $display("FAIL toggle_count beats got %0d (last seen %b) want 8", got.size(), done);
    end else begin
      for (int n = 0; n < 8; n++) begin
        checks++;
        if (got[n] !== w[8*sel_of(n) +: 8]) begin
          errors++;
          $display("FAIL toggle_byte%0d got %h want %h", n, got[n], w[8*sel_of(n) +: 8]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, selector} !== {1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL toggle_idle {ov,ir,sel} got %b_%b_%0d want 0_1_0", out_valid, in_ready, selector);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
